axi_read_responder: RTL and testbench

- AXI-style read-channel responder (slave): accepts one read-address request at a time and returns an incrementing burst of data beats from an internal word-addressed memory array.
- Acts as the memory-side endpoint for the instruction-fetch stream buffer and the caches in simulation and FPGA builds.
- Has a backdoor write port for program preload and testbench pokes.
- Configurable access latency, so prefetch timing can be exercised.

---
 rtl/axi_read_responder.sv | 147 ++++++++++++++
 tb/tb_axi_read_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
`default_nettype none
// ============================================================================
// axi_read_responder - AXI-style read responder: one request at a time, INCR
// bursts from a word-addressed array with a backdoor preload port. Rev 1.0
// ============================================================================
module axi_read_responder #(
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 2,
  parameter int ID_W         = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [ID_W-1:0]       arid,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_W-1:0]       rid,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  bd_we,
  input  logic [MEM_AW-1:0]     bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_wdata
);

  localparam int LAT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam logic [LAT_W-1:0] LAT_INIT =
    LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];

  state_t                state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_W-1:0]       rid_q;
  logic [MEM_AW-1:0]     addr_q;
  logic [8:0]            beats_q;
  logic [LAT_W-1:0]      lat_q;

  logic [MEM_AW-1:0]     req_addr_d;
  logic [MEM_AW-1:0]     addr_inc_d;
  logic                  unused_araddr;

  // Byte offset and bits above the array depth alias away.
  assign req_addr_d    = araddr[MEM_AW+1:2];
  assign addr_inc_d    = addr_q + MEM_AW'(1);
  assign unused_araddr = ^{araddr[ADDR_WIDTH-1:MEM_AW+2], araddr[1:0]};

  // Backdoor port is deliberately outside reset so preload survives it.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_q[bd_addr] <= bd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      addr_q    <= '0;
      beats_q   <= '0;
      lat_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            addr_q    <= req_addr_d;
            beats_q   <= {1'b0, arlen} + 9'd1;
            rid_q     <= arid;
            if (READ_LATENCY == 0) begin
              state_q  <= S_BURST;
              rvalid_q <= 1'b1;
              rlast_q  <= (arlen == 8'd0);
              rdata_q  <= mem_q[req_addr_d];
            end else begin
              state_q <= S_WAIT;
              lat_q   <= LAT_INIT;
            end
          end
        end

        S_WAIT: begin
          if (lat_q == '0) begin
            state_q  <= S_BURST;
            rvalid_q <= 1'b1;
            rlast_q  <= (beats_q == 9'd1);
            rdata_q  <= mem_q[addr_q];
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end

        S_BURST: begin
          if (rready) begin
            // Next beat is fetched on the handshake edge so beats stream back-to-back.
            if (beats_q > 9'd1) begin
              addr_q  <= addr_inc_d;
              beats_q <= beats_q - 9'd1;
              rlast_q <= (beats_q == 9'd2);
              rdata_q <= mem_q[addr_inc_d];
            end else begin
              state_q   <= S_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rdata   = rdata_q;
  assign rid     = rid_q;

  a_last_has_valid : assert property (@(posedge clk) disable iff (!rst_n)
    rlast |-> rvalid);
  a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n)
    rvalid |-> !arready);

endmodule
`default_nettype wire

// File: tb/tb_axi_read_responder.sv
`default_nettype none
module tb_axi_read_responder;

  localparam int AW = 10;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [3:0]  arid = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic        bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0] bd_wdata = '0;

  // act selects which instance is driven and observed: 0 -> latency 2, 1 -> latency 0
  int act = 0;
  logic av2, av0;
  assign av2 = arvalid && (act == 0);
  assign av0 = arvalid && (act == 1);

  logic        ar2, rv2, rl2, ar0, rv0, rl0;
  logic [31:0] rd2, rd0;
  logic [3:0]  id2, id0;

  always #5 clk = ~clk;

  axi_read_responder #(.MEM_AW(AW), .READ_LATENCY(2), .ID_W(4)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .araddr(araddr), .arlen(arlen), .arid(arid),
    .arvalid(av2), .arready(ar2), .rdata(rd2), .rid(id2), .rlast(rl2),
    .rvalid(rv2), .rready(rready), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_wdata(bd_wdata)
  );

  axi_read_responder #(.MEM_AW(AW), .READ_LATENCY(0), .ID_W(4)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .araddr(araddr), .arlen(arlen), .arid(arid),
    .arvalid(av0), .arready(ar0), .rdata(rd0), .rid(id0), .rlast(rl0),
    .rvalid(rv0), .rready(rready), .bd_we(bd_we), .bd_addr(bd_addr),
    .bd_wdata(bd_wdata)
  );

  logic        m_ar, m_rv, m_rl;
  logic [31:0] m_rd;
  logic [3:0]  m_id;
  assign m_ar = (act == 1) ? ar0 : ar2;
  assign m_rv = (act == 1) ? rv0 : rv2;
  assign m_rl = (act == 1) ? rl0 : rl2;
  assign m_rd = (act == 1) ? rd0 : rd2;
  assign m_id = (act == 1) ? id0 : id2;

  logic [31:0] mdl [1024];
  beat_t       exp_q [$];
  longint      acc_q [$];
  longint      cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  bit          in_burst = 1'b0;
  bit          chk_ar = 1'b0;
  int          rr_mode = 0;
  int          pat [7] = '{1, 0, 0, 1, 0, 1, 1};
  int          pidx = 0;
  beat_t       mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", nm, $time);
  endtask

  // Scoreboard monitor: every presented beat must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      in_burst = 1'b0;
      chk_ar   = 1'b0;
    end else begin
      if (chk_ar) begin
        check("arready_after_last", m_ar, 1);
        chk_ar = 1'b0;
      end
      if (m_rv) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          if (acc_q.size() == 0) fail("rvalid_without_request");
          else check("first_beat_latency", cyc - acc_q.pop_front(), (act == 1) ? 1 : 3);
        end
        if (exp_q.size() == 0) begin
          fail("spurious_beat");
        end else begin
          mon_e = exp_q[0];
          check("rdata", m_rd, mon_e.data);
          check("rid", m_id, mon_e.id);
          check("rlast", m_rl, mon_e.last);
          if (rready) begin
            void'(exp_q.pop_front());
            if (mon_e.last) begin
              in_burst = 1'b0;
              chk_ar   = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = ($urandom_range(0, 1) == 1);
        default: begin
          if (m_rv) begin
            rready = (pidx < 7) ? (pat[pidx] != 0) : 1'b1;
            pidx++;
          end else begin
            rready = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic bd_write(input int a, input logic [31:0] d);
    bd_we = 1'b1;
    bd_addr = AW'(a);
    bd_wdata = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    mdl[a] = d;
  endtask

  // Holds arvalid until accepted, then records the expected burst from the model array.
  task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [3:0] id);
    int t = 0;
    beat_t b;
    araddr = a;
    arlen = l;
    arid = id;
    arvalid = 1'b1;
    @(negedge clk);
    while (!m_ar && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!m_ar) begin
      fail("accept_timeout");
    end else begin
      for (int i = 0; i <= int'(l); i++) begin
        b.data = mdl[(int'(a[AW+1:2]) + i) % 1024];
        b.id   = id;
        b.last = (i == int'(l));
        exp_q.push_back(b);
      end
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("arready_low_after_accept", m_ar, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || !m_ar) && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 6000) fail("idle_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input int n);
    int t = 0;
    int nv = 0;
    while (nv < n && t < 50) begin
      @(posedge clk);
      #1;
      t++;
      if (m_rv) nv++;
    end
    if (nv < n) fail("rvalid_timeout");
  endtask

  initial begin
    rst_n = 1'b0;
    // Preload runs entirely under reset, so it also shows reset does not block the backdoor.
    for (int i = 0; i < 1024; i++) bd_write(i, $urandom);
    for (int i = 0; i < 16; i++) bd_write(i, 32'h1000 + i);

    @(negedge clk);
    check("reset_rvalid2", rv2, 0);
    check("reset_rlast2", rl2, 0);
    check("reset_rid2", id2, 0);
    check("reset_rdata2", rd2, 0);
    check("reset_arready2", ar2, 0);
    check("reset_rvalid0", rv0, 0);
    check("reset_arready0", ar0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("arready_before_release_edge", ar2, 0);
    @(negedge clk);
    check("arready_after_release2", ar2, 1);
    check("arready_after_release0", ar0, 1);
    @(posedge clk);
    #1;

    // Basic 4-beat burst, then the same burst under rready back-pressure.
    act = 0;
    rr_mode = 0;
    issue(32'h0000_0010, 8'd3, 4'd2);
    wait_idle();
    rr_mode = 2;
    pidx = 0;
    issue(32'h0000_0010, 8'd3, 4'd2);
    wait_idle();
    rr_mode = 0;

    // Wrap at the top of the array, plus an aliased high address.
    issue(32'(1023 << 2), 8'd1, 4'd5);
    wait_idle();
    issue(32'hABCD_0FFC, 8'd2, 4'd6);
    wait_idle();

    // Zero-latency instance.
    act = 1;
    issue(32'h0000_0008, 8'd0, 4'd7);
    wait_idle();
    issue(32'h0000_0020, 8'd5, 4'd3);
    wait_idle();

    // Reset during beat 2 of 8, with a backdoor write landing on the reset edge.
    act = 0;
    issue(32'h0000_0080, 8'd7, 4'd4);
    wait_rvalid(2);
    rst_n = 1'b0;
    bd_we = 1'b1;
    bd_addr = AW'(32);
    bd_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    mdl[32] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("abort_rvalid", rv2, 0);
    check("abort_rlast", rl2, 0);
    check("abort_rid", id2, 0);
    check("abort_arready", ar2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("arready_after_abort", ar2, 1);
    @(posedge clk);
    #1;
    issue(32'h0000_0080, 8'd3, 4'd9);
    wait_idle();

    // Backdoor write to the next beat's word on the current beat's handshake edge.
    issue(32'h0000_0100, 8'd3, 4'd1);
    wait_rvalid(1);
    bd_we = 1'b1;
    bd_addr = AW'(65);
    bd_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    mdl[65] = 32'hCAFE_F00D;
    wait_idle();
    issue(32'h0000_0100, 8'd3, 4'd1);
    wait_idle();

    // Maximum-length burst.
    issue(32'h0000_0F00, 8'd255, 4'd15);
    wait_idle();

    // Randomized back-to-back traffic on both instances with random back-pressure.
    for (int k = 0; k < 2; k++) begin
      act = k;
      rr_mode = 1;
      for (int n = 0; n < 40; n++) begin
        issue($urandom,
              ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 60)) : 8'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)));
      end
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #600000;
    fail("global_watchdog");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
